sound_player: RTL
=================

SOUND_PLAYER -- requirements
Module: sound_player

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency in Hz.
REQ-002 Parameter NOTE_MS, default 100, duration of one note in milliseconds.
REQ-003 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 Port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port code_sound, input, 2 bits: sound code; 00 ping, 01 pong, 10 go, 11 stop.
REQ-006 Port mute, input, 1 bit: when 1, silences the speaker output.
REQ-007 Port speaker, output, 1 bit: square-wave audio output to the piezo/speaker pin.
REQ-008 Port busy, output, 1 bit: 1 while a sound sequence is playing.

Function
REQ-009 Derived constants, integer division: NOTE_CYC = (CLK_HZ/1000)*NOTE_MS; HALF_HI = CLK_HZ/2000 (1000 Hz tone); HALF_LO = CLK_HZ/1000 (500 Hz tone).
REQ-010 Sequences: ping = one HI note; pong = one LO note; go = LO note then HI note; stop = HI note then LO note; no gap between notes.
REQ-011 FSM states: ARM, IDLE, NOTE1, NOTE2.
REQ-012 ARM is entered only from reset; on the first clock edge it captures code_sound into prev_code without triggering, then moves to IDLE.
REQ-013 Event: an edge where code_sound differs from prev_code; prev_code updates on every edge outside ARM.
REQ-014 A repeated identical code is not an event and is not replayed.
REQ-015 IDLE plus event at edge N: latch code, load note counter and tone counter, enter NOTE1; busy=1 and internal tone=1 from edge N+1.
REQ-016 Tone counter toggles the internal tone after every HALF_x cycles of the current note.
REQ-017 Each note lasts exactly NOTE_CYC cycles.
REQ-018 End of NOTE1: ping/pong go to IDLE; go/stop enter NOTE2 with tone restarted at 1.
REQ-019 End of NOTE2: go to IDLE.
REQ-020 In IDLE: busy=0, tone=0.
REQ-021 speaker = tone AND NOT mute, registered; mute does not alter FSM timing.
REQ-022 mute toggled mid-note gates the output only; the sequence length is unchanged.
REQ-023 An event during NOTE1/NOTE2 is handled per REQ-028/REQ-029.
REQ-024 An event on the same edge as sequence end is treated as an IDLE event; the new sequence starts next cycle with no idle cycle.

Reset
REQ-025 clr=0 forces asynchronously: state ARM, speaker 0, busy 0, all counters 0, prev_code 00, pending flag 0.
REQ-026 clr asserted mid-note aborts playback immediately; no sound resumes after release until a new event.

Configuration
REQ-027 Macro SOUND_RETRIGGER_EN selects event handling during playback.
REQ-028 Defined: an event during playback aborts the current sequence and starts the new one on the next edge, per REQ-015.
REQ-029 Undefined: an event during playback is stored in a one-deep pending register, latest code wins; it starts in place of IDLE when the current sequence ends.

Verification (CLK_HZ=100000, NOTE_MS=2: NOTE_CYC=200, HALF_HI=50, HALF_LO=100)
REQ-030 Reset release with code 10 held -> no sound; busy stays 0 for 500 cycles.
REQ-031 Code 00->01 at edge N -> busy=1 on cycles N+1..N+200; speaker period 200 cycles (100 high, 100 low); busy=0 at N+201.
REQ-032 Code ->10 (go) -> 200 cycles of period-200 tone then 200 cycles of period-100 tone; busy high for 400 cycles.
REQ-033 mute=1 during a stop sequence -> speaker constantly 0; busy still high for exactly 400 cycles.
REQ-034 Code change at cycle 50 of a ping -> with SOUND_RETRIGGER_EN the new sequence starts at cycle 51; without it, starts right after cycle 200.
REQ-035 clr pulsed low at cycle 100 of a pong -> speaker and busy 0 at once; remain 0 after release with code unchanged.

Source files
------------

// File: rtl/sound_player.sv
// ---------------------------------------------------------------------------
// sound_player
//   Plays short two-tone sound effects on a piezo/speaker pin. A sound starts
//   when code_sound changes value:
//     00 ping : one high note
//     01 pong : one low note
//     10 go   : low note, then high note
//     11 stop : high note, then low note
//   Every note lasts NOTE_MS milliseconds. The high note is a 1000 Hz square
//   wave and the low note is a 500 Hz square wave. There is no gap between
//   the two notes of a sequence.
//
//   Build option SOUND_RETRIGGER_EN:
//     defined   - a code change during playback aborts the current sound and
//                 starts the new one on the next clock edge.
//     undefined - a code change during playback is held in a one-deep
//                 pending slot, where the latest code overwrites any earlier
//                 one. The held sound starts when the current one ends.
//
// Ports
//   clk        in   system clock; all state updates on its rising edge
//   clr        in   asynchronous active-low reset
//   code_sound in   [1:0] sound code
//   mute       in   forces the speaker low without changing the timing
//   speaker    out  registered square-wave output
//   busy       out  high while a sound sequence is playing
// ---------------------------------------------------------------------------
module sound_player #(
  parameter int CLK_HZ  = 25000000,
  parameter int NOTE_MS = 100
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] code_sound,
  input  logic       mute,
  output logic       speaker,
  output logic       busy
);

  localparam int NOTE_CYC = (CLK_HZ / 1000) * NOTE_MS;
  localparam int HALF_HI  = CLK_HZ / 2000;
  localparam int HALF_LO  = CLK_HZ / 1000;
  localparam int NW       = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
  localparam int TW       = (HALF_LO > 1) ? $clog2(HALF_LO) : 1;

  // The counters count down to zero, so they are loaded with (length - 1).
  localparam logic [NW-1:0] NOTE_LOAD = NW'(NOTE_CYC - 1);
  localparam logic [TW-1:0] HI_LOAD   = TW'(HALF_HI - 1);
  localparam logic [TW-1:0] LO_LOAD   = TW'(HALF_LO - 1);

  localparam logic [1:0] CODE_PONG = 2'b01;
  localparam logic [1:0] CODE_GO   = 2'b10;

  typedef enum logic [1:0] {ARM, IDLE, NOTE1, NOTE2} state_t;

  // Half-period reload for the first and second note of each sequence.
  function automatic logic [TW-1:0] first_load(input logic [1:0] c);
    return (c == CODE_PONG || c == CODE_GO) ? LO_LOAD : HI_LOAD;
  endfunction

  function automatic logic [TW-1:0] second_load(input logic [1:0] c);
    return (c == CODE_GO) ? HI_LOAD : LO_LOAD;
  endfunction

  state_t        state, state_nxt;
  logic [1:0]    prev_code;
  logic [1:0]    cur_code, cur_code_nxt;
  logic [NW-1:0] note_cnt, note_cnt_nxt;
  logic [TW-1:0] tone_cnt, tone_cnt_nxt;
  logic          tone, tone_nxt;
  logic          code_event;
  logic          seq_end;
  logic          start_seq;
  logic [1:0]    start_code;
  logic [TW-1:0] tone_load;
`ifndef SOUND_RETRIGGER_EN
  logic          pend_valid, pend_valid_nxt;
  logic [1:0]    pend_code, pend_code_nxt;
`endif

  assign code_event = (code_sound != prev_code);
  assign busy       = (state == NOTE1) || (state == NOTE2);

  always_comb begin
    // NOTE: every variable gets a default here first, so no path through the
    // block leaves a value unassigned and no latch is inferred.
    state_nxt    = state;
    cur_code_nxt = cur_code;
    note_cnt_nxt = note_cnt;
    tone_cnt_nxt = tone_cnt;
    tone_nxt     = tone;
    seq_end      = 1'b0;
    start_seq    = 1'b0;
    start_code   = code_sound;
    tone_load    = (state == NOTE2) ? second_load(cur_code) : first_load(cur_code);
`ifndef SOUND_RETRIGGER_EN
    pend_valid_nxt = pend_valid;
    pend_code_nxt  = pend_code;
`endif

    case (state)
      // The first edge after reset only records the code. A level that is
      // held through reset must not play.
      ARM: state_nxt = IDLE;

      IDLE: begin
        tone_nxt = 1'b0;
        if (code_event) start_seq = 1'b1;
      end

      NOTE1, NOTE2: begin
        if (tone_cnt == '0) begin
          tone_nxt     = ~tone;
          tone_cnt_nxt = tone_load;
        end else begin
          tone_cnt_nxt = tone_cnt - 1'b1;
        end

        if (note_cnt == '0) begin
          // go (10) and stop (11) are the two-note sequences.
          if (state == NOTE1 && cur_code[1]) begin
            state_nxt    = NOTE2;
            note_cnt_nxt = NOTE_LOAD;
            tone_cnt_nxt = second_load(cur_code);
            tone_nxt     = 1'b1;
          end else begin
            seq_end   = 1'b1;
            state_nxt = IDLE;
            tone_nxt  = 1'b0;
          end
        end else begin
          note_cnt_nxt = note_cnt - 1'b1;
        end

`ifdef SOUND_RETRIGGER_EN
        if (code_event) start_seq = 1'b1;
`else
        if (code_event) begin
          // A change on the last edge of a sequence is handled as if the
          // player were idle, so it starts with no idle cycle in between.
          if (seq_end) begin
            start_seq      = 1'b1;
            pend_valid_nxt = 1'b0;
          end else begin
            pend_valid_nxt = 1'b1;
            pend_code_nxt  = code_sound;
          end
        end else if (seq_end && pend_valid) begin
          start_seq      = 1'b1;
          start_code     = pend_code;
          pend_valid_nxt = 1'b0;
        end
`endif
      end

      default: state_nxt = ARM;
    endcase

    // Starting a sequence overrides whatever the note logic above chose.
    if (start_seq) begin
      state_nxt    = NOTE1;
      cur_code_nxt = start_code;
      note_cnt_nxt = NOTE_LOAD;
      tone_cnt_nxt = first_load(start_code);
      tone_nxt     = 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so that every flop samples
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= ARM;
      prev_code  <= 2'b00;
      cur_code   <= 2'b00;
      note_cnt   <= '0;
      tone_cnt   <= '0;
      tone       <= 1'b0;
      speaker    <= 1'b0;
`ifndef SOUND_RETRIGGER_EN
      pend_valid <= 1'b0;
      pend_code  <= 2'b00;
`endif
    end else begin
      state      <= state_nxt;
      prev_code  <= code_sound;
      cur_code   <= cur_code_nxt;
      note_cnt   <= note_cnt_nxt;
      tone_cnt   <= tone_cnt_nxt;
      tone       <= tone_nxt;
      speaker    <= tone & ~mute;
`ifndef SOUND_RETRIGGER_EN
      pend_valid <= pend_valid_nxt;
      pend_code  <= pend_code_nxt;
`endif
    end
  end

endmodule
